// File: rtl/alu_multicycle_sliced_pkg.sv
// Shared op codes, FSM state encodings and the MSB flag helper for the sliced ALU.
package alu_multicycle_sliced_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SLT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {overflow, set}; set is the true sign of a-b even when the subtraction overflows.
  function automatic logic [1:0] msb_flags(input logic a_msb, input logic b2_msb, input logic sum_msb);
    logic ovf;
    logic set;
    ovf = (a_msb == b2_msb) && (sum_msb != a_msb);
    set = (a_msb != b2_msb) ? sum_msb : a_msb;
    return {ovf, set};
  endfunction

endpackage

// File: rtl/alu_multicycle_sliced_if.sv
// Operand-side and result-side valid/ready bus of the sliced ALU.
interface alu_multicycle_sliced_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             binvert;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, binvert, out_ready,
    input  in_ready, out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, binvert, out_ready,
    output in_ready, out_valid, result, overflow, zero
  );
endinterface

// File: rtl/alu_multicycle_sliced_slice_k.sv
// Combinational K-bit ALU slice, reused every cycle by the sliced ALU.
module alu_slice_k
  import alu_multicycle_sliced_pkg::*;
#(
  parameter int K = 4
) (
  input  logic [K-1:0] i_a,
  input  logic [K-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_binvert,
  input  op_e          i_op,
  output logic [K-1:0] o_res,
  output logic [K-1:0] o_sum,
  output logic         o_cout
);

  logic [K-1:0] w_b2;
  logic [K:0]   w_full;

  // Slice adder and logic-op selection; AND/OR deliberately use the un-inverted b.
  always_comb begin
    w_b2   = i_binvert ? ~i_b : i_b;
    w_full = {1'b0, i_a} + {1'b0, w_b2} + {{K{1'b0}}, i_cin};
    o_sum  = w_full[K-1:0];
    o_cout = w_full[K];
    case (i_op)
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_ADD:  o_res = w_full[K-1:0];
      OP_SLT:  o_res = w_full[K-1:0];
      default: o_res = {K{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_multicycle_sliced.sv
// Multi-cycle ALU: one SLICE-bit slice per cycle, LSB slice first, carry kept in a register.
module alu_multicycle_sliced
  import alu_multicycle_sliced_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  alu_multicycle_sliced_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  op_e                r_op;
  logic               r_binv;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  int                 w_base;
  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_sl;
  logic [SLICE-1:0]   w_res_sl;
  logic [SLICE-1:0]   w_sum_sl;
  logic               w_cout;
  logic [1:0]         w_flags;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_final;
  logic               w_ovf_final;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_base   = int'(r_cnt) * SLICE;
  assign w_a_sl   = r_a[w_base +: SLICE];
  assign w_b_sl   = r_b[w_base +: SLICE];

  alu_slice_k #(.K(SLICE)) u_slice (
    .i_a       (w_a_sl),
    .i_b       (w_b_sl),
    .i_cin     (r_carry),
    .i_binvert (r_binv),
    .i_op      (r_op),
    .o_res     (w_res_sl),
    .o_sum     (w_sum_sl),
    .o_cout    (w_cout)
  );

  assign w_flags = msb_flags(w_a_sl[SLICE-1], r_binv ^ w_b_sl[SLICE-1], w_sum_sl[SLICE-1]);

  // Final result assembly; the output register only ever sees complete results.
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[w_base +: SLICE] = w_res_sl;
    if (r_op == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_flags[0]};
    end else begin
      w_final = w_acc_nxt;
    end
    w_ovf_final = (r_op == OP_ADD) && w_flags[1];
  end

  // Input acceptance: in DONE a new op may be taken in the same cycle the result drains.
  always_comb begin
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_DONE: w_in_ready = bus.out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = bus.in_valid ? ST_RUN : ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, per-slice carry/accumulator update and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_AND;
      r_binv   <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_op    <= op_e'(bus.op);
      r_binv  <= bus.binvert;
      r_carry <= bus.binvert;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == ST_RUN) begin
      r_carry <= w_cout;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_last ? r_cnt : r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_final;
        r_ovf    <= w_ovf_final;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = (r_result == '0);

endmodule
